// File: rtl/multi_stable_checker_if.sv
// multi_stable_checker_if: control, channel data and status bundle for the stability checker
interface multi_stable_checker_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int CH_W     = CHANNELS > 1 ? $clog2(CHANNELS) : 1
);
  logic                      en;
  logic                      clr;
  logic [1:0]                mode;
  logic [CHANNELS-1:0]       ant;
  logic [CHANNELS*WIDTH-1:0] data;
  logic [CHANNELS-1:0]       pass;
  logic [CHANNELS-1:0]       fail;
  logic                      err_sticky;
  logic [CNT_W-1:0]          pass_cnt;
  logic [CNT_W-1:0]          fail_cnt;
  logic                      first_fail_vld;
  logic [CH_W-1:0]           first_fail_ch;
  logic [CNT_W-1:0]          first_fail_cyc;
  modport master (
    output en, clr, mode, ant, data,
    input  pass, fail, err_sticky, pass_cnt, fail_cnt, first_fail_vld, first_fail_ch, first_fail_cyc
  );
  modport slave (
    input  en, clr, mode, ant, data,
    output pass, fail, err_sticky, pass_cnt, fail_cnt, first_fail_vld, first_fail_ch, first_fail_cyc
  );
endinterface

// File: rtl/multi_stable_checker.sv
// multi_stable_checker: per-channel $stable/$changed/$rose/$fell monitor with counters and first-fail capture
module multi_stable_checker #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int CH_W     = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input logic clk,
  input logic rst,
  multi_stable_checker_if.slave bus
);
  localparam int PC_W = $clog2(CHANNELS + 1);
  localparam int SW = (CNT_W > PC_W ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CHANNELS*WIDTH-1:0] prev;
  logic [CNT_W-1:0]          cyc;
  logic [CHANNELS-1:0]       pass_nxt;
  logic [CHANNELS-1:0]       fail_nxt;
  logic [PC_W-1:0]           n_pass;
  logic [PC_W-1:0]           n_fail;
  logic [CH_W-1:0]           low_fail;
  function automatic logic cond_of(input logic [1:0] m, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p);
    return m == 2'b00 ? d == p : m == 2'b01 ? d != p : m == 2'b10 ? !p[0] && d[0] : p[0] && !d[0];
  endfunction
  // sum is widened so a popcount larger than the counter range still clamps
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return s > SW'(CNT_MAX) ? CNT_MAX : s[CNT_W-1:0];
  endfunction
  always_comb begin
    pass_nxt = '0;
    fail_nxt = '0;
    n_pass = '0;
    n_fail = '0;
    low_fail = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      pass_nxt[k] = bus.en && bus.ant[k] && cond_of(bus.mode, bus.data[k*WIDTH +: WIDTH], prev[k*WIDTH +: WIDTH]);
      fail_nxt[k] = bus.en && bus.ant[k] && !cond_of(bus.mode, bus.data[k*WIDTH +: WIDTH], prev[k*WIDTH +: WIDTH]);
      n_pass = n_pass + PC_W'(pass_nxt[k]);
      n_fail = n_fail + PC_W'(fail_nxt[k]);
      low_fail = fail_nxt[k] ? CH_W'(k) : low_fail;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      cyc <= '0;
      bus.pass <= '0;
      bus.fail <= '0;
      bus.err_sticky <= 1'b0;
      bus.pass_cnt <= '0;
      bus.fail_cnt <= '0;
      bus.first_fail_vld <= 1'b0;
      bus.first_fail_ch <= '0;
      bus.first_fail_cyc <= '0;
    end else begin
      prev <= bus.data;
      cyc <= cyc + 1'b1;
      bus.pass <= pass_nxt;
      bus.fail <= fail_nxt;
      if (bus.clr) begin
        bus.err_sticky <= 1'b0;
        bus.pass_cnt <= '0;
        bus.fail_cnt <= '0;
        bus.first_fail_vld <= 1'b0;
        bus.first_fail_ch <= '0;
        bus.first_fail_cyc <= '0;
      end else begin
        bus.pass_cnt <= sat_add(bus.pass_cnt, n_pass);
        bus.fail_cnt <= sat_add(bus.fail_cnt, n_fail);
        if (|fail_nxt) bus.err_sticky <= 1'b1;
        if (|fail_nxt && !bus.first_fail_vld) begin
          bus.first_fail_vld <= 1'b1;
          bus.first_fail_ch <= low_fail;
          bus.first_fail_cyc <= cyc;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_stable_checker.sv
// tb_multi_stable_checker: directed stimulus with a cycle-level reference model and literal spot checks
module tb_multi_stable_checker;
  logic clk;
  logic rst;
  int checks = 0;
  int failures = 0;
  multi_stable_checker_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(4), .CH_W(2)) bus ();
  multi_stable_checker #(.WIDTH(8), .CHANNELS(4), .CNT_W(4), .CH_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int m_prev[4];
  int m_cyc, m_pcnt, m_fcnt, m_ffch, m_ffcyc;
  bit [3:0] m_pass, m_fail;
  bit m_err, m_ffv, started;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  task automatic model_step();
    int np, nf, lf, d, p;
    bit c;
    if (rst) begin
      foreach (m_prev[k]) m_prev[k] = 0;
      m_cyc = 0; m_pcnt = 0; m_fcnt = 0; m_ffch = 0; m_ffcyc = 0;
      m_pass = 0; m_fail = 0; m_err = 0; m_ffv = 0;
      return;
    end
    np = 0; nf = 0; lf = -1; m_pass = 0; m_fail = 0;
    for (int k = 0; k < 4; k++) begin
      d = int'(bus.data[k*8 +: 8]);
      p = m_prev[k];
      case (bus.mode)
        2'd0: c = d == p;
        2'd1: c = d != p;
        2'd2: c = (p % 2 == 0) && (d % 2 == 1);
        default: c = (p % 2 == 1) && (d % 2 == 0);
      endcase
      if (bus.en && bus.ant[k]) begin
        if (c) begin m_pass[k] = 1; np++; end
        else begin m_fail[k] = 1; nf++; if (lf < 0) lf = k; end
      end
      m_prev[k] = d;
    end
    if (bus.clr) begin
      m_pcnt = 0; m_fcnt = 0; m_err = 0; m_ffv = 0; m_ffch = 0; m_ffcyc = 0;
    end else begin
      m_pcnt = (m_pcnt + np > 15) ? 15 : m_pcnt + np;
      m_fcnt = (m_fcnt + nf > 15) ? 15 : m_fcnt + nf;
      if (nf > 0) begin
        m_err = 1;
        if (!m_ffv) begin m_ffv = 1; m_ffch = lf; m_ffcyc = m_cyc; end
      end
    end
    m_cyc = (m_cyc + 1) % 16;
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
    started = 1;
  end
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("m_pass", 32'(bus.pass), 32'(m_pass));
      chk("m_fail", 32'(bus.fail), 32'(m_fail));
      chk("m_err_sticky", 32'(bus.err_sticky), 32'(m_err));
      chk("m_pass_cnt", 32'(bus.pass_cnt), m_pcnt);
      chk("m_fail_cnt", 32'(bus.fail_cnt), m_fcnt);
      chk("m_ff_vld", 32'(bus.first_fail_vld), 32'(m_ffv));
      chk("m_ff_ch", 32'(bus.first_fail_ch), m_ffch);
      chk("m_ff_cyc", 32'(bus.first_fail_cyc), m_ffcyc);
    end
  end
  task automatic drive(input bit a_en, input bit a_clr, input bit [1:0] a_mode, input bit [3:0] a_ant, input bit [31:0] a_data);
    bus.en = a_en; bus.clr = a_clr; bus.mode = a_mode; bus.ant = a_ant; bus.data = a_data;
    @(negedge clk);
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_pass"}, 32'(bus.pass), 0);
    chk({nm, "_fail"}, 32'(bus.fail), 0);
    chk({nm, "_sticky"}, 32'(bus.err_sticky), 0);
    chk({nm, "_pcnt"}, 32'(bus.pass_cnt), 0);
    chk({nm, "_fcnt"}, 32'(bus.fail_cnt), 0);
    chk({nm, "_ffv"}, 32'(bus.first_fail_vld), 0);
    chk({nm, "_ffch"}, 32'(bus.first_fail_ch), 0);
    chk({nm, "_ffcyc"}, 32'(bus.first_fail_cyc), 0);
  endtask
  initial begin
    bit t1_ant[6] = '{0, 1, 1, 0, 1, 1};
    bit [7:0] t1_dat[6] = '{1, 0, 1, 0, 1, 1};
    bit t1_f[6] = '{0, 1, 1, 0, 1, 0};
    bit t1_p[6] = '{0, 0, 0, 0, 0, 1};
    bit [7:0] t2_dat[3] = '{1, 1, 0};
    bit t2_p[4][3] = '{'{0, 1, 0}, '{1, 0, 1}, '{1, 0, 0}, '{0, 0, 1}};
    rst = 1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_all_zero("reset");
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, {3'b0, t1_ant[i]}, {24'b0, t1_dat[i]});
      chk("t1_fail", 32'(bus.fail[0]), 32'(t1_f[i]));
      chk("t1_pass", 32'(bus.pass[0]), 32'(t1_p[i]));
    end
    chk("t1_fail_cnt", 32'(bus.fail_cnt), 3);
    chk("t1_pass_cnt", 32'(bus.pass_cnt), 1);
    chk("t1_ff_ch", 32'(bus.first_fail_ch), 0);
    chk("t1_ff_cyc", 32'(bus.first_fail_cyc), 1);
    chk("t1_sticky", 32'(bus.err_sticky), 1);
    for (int m = 0; m < 4; m++) begin
      drive(1, 0, 2'(m), 0, 0);
      for (int i = 0; i < 3; i++) begin
        drive(1, 0, 2'(m), 4'b0001, {24'b0, t2_dat[i]});
        chk("t2_mode_pass", 32'(bus.pass[0]), 32'(t2_p[m][i]));
        chk("t2_mode_fail", 32'(bus.fail[0]), 32'(!t2_p[m][i]));
      end
    end
    rst = 1;
    drive(0, 0, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 4'hF, {8'd9, 8'd0, 8'd5, 8'd0});
    chk("t3_fail_vec", 32'(bus.fail), 32'h0A);
    chk("t3_pass_vec", 32'(bus.pass), 32'h05);
    chk("t3_fail_cnt", 32'(bus.fail_cnt), 2);
    chk("t3_ff_ch", 32'(bus.first_fail_ch), 1);
    chk("t3_ff_cyc", 32'(bus.first_fail_cyc), 7);
    drive(1, 0, 0, 4'b0001, {8'd9, 8'd0, 8'd5, 8'd3});
    chk("t3_later_fail", 32'(bus.fail), 32'h01);
    chk("t3_fail_cnt2", 32'(bus.fail_cnt), 3);
    chk("t3_ff_ch_kept", 32'(bus.first_fail_ch), 1);
    chk("t3_ff_cyc_kept", 32'(bus.first_fail_cyc), 7);
    drive(1, 1, 0, 0, 0);
    chk("t4_clr_pcnt", 32'(bus.pass_cnt), 0);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 4'b0001, 0);
    chk("t4_sat20", 32'(bus.pass_cnt), 15);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 4'b0011, 0);
    chk("t4_at14", 32'(bus.pass_cnt), 14);
    drive(1, 0, 0, 4'b0011, 0);
    chk("t4_14p2", 32'(bus.pass_cnt), 15);
    drive(1, 0, 0, 4'hF, 0);
    chk("t4_hold", 32'(bus.pass_cnt), 15);
    drive(1, 0, 0, 4'b0001, 32'd7);
    chk("t5_pre_sticky", 32'(bus.err_sticky), 1);
    drive(1, 1, 0, 4'b0001, 32'd9);
    chk("t5_clr_pulse", 32'(bus.fail[0]), 1);
    chk("t5_clr_fcnt", 32'(bus.fail_cnt), 0);
    chk("t5_clr_sticky", 32'(bus.err_sticky), 0);
    chk("t5_clr_ffv", 32'(bus.first_fail_vld), 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 4'hF, {4{8'(i)}});
      chk("t5_en0_pulses", 32'({bus.pass, bus.fail}), 0);
    end
    drive(1, 0, 0, 4'b0001, {4{8'd3}});
    chk("t5_reen_pass", 32'(bus.pass[0]), 1);
    drive(1, 0, 0, 4'hF, {4{8'd4}});
    chk("t6_pre_sticky", 32'(bus.err_sticky), 1);
    chk("t6_pre_fcnt", 32'(bus.fail_cnt), 4);
    rst = 1;
    drive(1, 0, 0, 4'hF, {4{8'd6}});
    chk_all_zero("t6_rst");
    rst = 0;
    drive(1, 0, 0, 4'b0001, 0);
    chk("t6_post_pass", 32'(bus.pass[0]), 1);
    chk("t6_post_fail", 32'(bus.fail[0]), 0);
    drive(0, 0, 0, 0, 0);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
